uart_boot_ctrl: RTL and testbench

- Sequences program download from the UART receiver into instruction memory.
- Detects the "_p" start sequence and holds the core in reset for the whole transfer.
- Reads a 16-bit word count, packs payload bytes into little-endian 32-bit words and writes them through a req/gnt memory port.
- Verifies an 8-bit checksum, then releases the core. Sits between the UART RX, the imem write port and the core reset input.

---
 rtl/uart_boot_pkg.sv | 18 +
 rtl/boot_word_packer.sv | 47 ++++
 rtl/uart_boot_ctrl.sv | 160 ++++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE0 = 8'h5F;  // '_'
    localparam logic [7:0] SYNC_BYTE1 = 8'h70;  // 'p'

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 50_000_000;

endpackage

// File: rtl/boot_word_packer.sv
// Packs payload bytes LSB-lane-first into 32-bit words and keeps the
// running mod-256 checksum of every byte accepted.
module boot_word_packer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o,
    output logic [7:0]  csum_o
);

    logic [1:0]  lane_q;
    logic [23:0] asm_q;
    logic [7:0]  csum_q;

    // The top lane is never stored: the completed word is formed from the
    // three held lanes plus the byte arriving in this cycle.
    assign word_done_o = byte_valid_i && (lane_q == 2'd3);
    assign word_o      = {byte_i, asm_q};
    assign csum_o      = csum_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            lane_q <= 2'd0;
            asm_q  <= '0;
            csum_q <= '0;
        end else if (clear_i) begin
            lane_q <= 2'd0;
            asm_q  <= '0;
            csum_q <= '0;
        end else if (byte_valid_i) begin
            lane_q <= lane_q + 2'd1;
            csum_q <= csum_q + byte_i;
            case (lane_q)
                2'd0:    asm_q[7:0]   <= byte_i;
                2'd1:    asm_q[15:8]  <= byte_i;
                2'd2:    asm_q[23:16] <= byte_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART program loader: "_p", 16-bit word count, payload, checksum.
// Define UART_BOOT_TIMEOUT_EN to abort a load after TIMEOUT_CYC idle clocks.
module uart_boot_ctrl
    import uart_boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = 26
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    if (64'(TIMEOUT_CYC) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYC");
    end

    boot_state_e       state_q;
    logic              req_q, core_rst_n_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       len_q, word_cnt_q;
    logic              csum_seen_q, csum_match_q;

    logic        start, data_byte, word_done, timeout;
    logic [31:0] word;
    logic [7:0]  csum;

    assign start     = rx_valid_i && (state_q == SYNC) && (rx_byte_i == SYNC_BYTE1);
    assign data_byte = rx_valid_i && (state_q == DATA);

    boot_word_packer u_packer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (start),
        .byte_valid_i(data_byte),
        .byte_i      (rx_byte_i),
        .word_o      (word),
        .word_done_o (word_done),
        .csum_o      (csum)
    );

`ifdef UART_BOOT_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt_q;
    logic             loading;

    assign loading = state_q inside {LEN_LO, LEN_HI, DATA, CSUM};
    assign timeout = loading && !rx_valid_i && (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)                            idle_cnt_q <= '0;
        else if (!loading || rx_valid_i || timeout) idle_cnt_q <= '0;
        else                                     idle_cnt_q <= idle_cnt_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            wdata_q      <= '0;
            core_rst_n_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            csum_seen_q  <= 1'b0;
            csum_match_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A grant retires the write; a word queued in the same cycle
            // below overrides req_q back to 1 at the incremented address.
            if (req_q && mem_gnt_i) begin
                req_q  <= 1'b0;
                addr_q <= addr_q + 1'b1;
            end
            if (timeout) begin
                err_q   <= 1'b1;
                req_q   <= 1'b0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (rx_valid_i && rx_byte_i == SYNC_BYTE0) state_q <= SYNC;
                    SYNC: if (rx_valid_i) begin
                        if (rx_byte_i == SYNC_BYTE1) begin
                            state_q      <= LEN_LO;
                            core_rst_n_q <= 1'b0;
                            err_q        <= 1'b0;
                            addr_q       <= ADDR_W'(BASE_ADDR);
                            word_cnt_q   <= '0;
                            csum_seen_q  <= 1'b0;
                        end else if (rx_byte_i != SYNC_BYTE0) begin
                            state_q <= IDLE;
                        end
                    end
                    LEN_LO: if (rx_valid_i) begin
                        len_q[7:0] <= rx_byte_i;
                        state_q    <= LEN_HI;
                    end
                    LEN_HI: if (rx_valid_i) begin
                        len_q[15:8] <= rx_byte_i;
                        state_q     <= ({rx_byte_i, len_q[7:0]} == 16'd0) ? CSUM : DATA;
                    end
                    DATA: if (word_done) begin
                        if (req_q && !mem_gnt_i) begin
                            err_q   <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            wdata_q    <= word;
                            req_q      <= 1'b1;
                            word_cnt_q <= word_cnt_q + 16'd1;
                            if (word_cnt_q + 16'd1 == len_q) state_q <= CSUM;
                        end
                    end
                    CSUM: begin
                        // The checksum byte may arrive while the last write
                        // is still pending; remember it and decide later.
                        if ((csum_seen_q || rx_valid_i) && !req_q) begin
                            if (csum_seen_q ? csum_match_q : (rx_byte_i == csum)) begin
                                core_rst_n_q <= 1'b1;
                                done_q       <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end else if (rx_valid_i && !csum_seen_q) begin
                            csum_seen_q  <= 1'b1;
                            csum_match_q <= (rx_byte_i == csum);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_rst_n_o = core_rst_n_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Randomized bench for uart_boot_ctrl against a transaction-level load model.
// Timeout checks follow UART_BOOT_TIMEOUT_EN.
module tb_uart_boot_ctrl;

    localparam int unsigned TB_ADDR_W  = 4;
    localparam int unsigned TB_BASE    = 0;
    localparam int unsigned TB_TIMEOUT = 100;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 rx_valid_i;
    logic [7:0]           rx_byte_i;
    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic [TB_ADDR_W-1:0] mem_addr_o;
    logic [31:0]          mem_wdata_o;
    logic                 core_rst_n_o, busy_o, done_o, err_o;

    int n_vec = 0;
    int n_err = 0;

    int gnt_delay = 0;
    bit gnt_block = 1'b0;
    bit gnt_noise = 1'b0;
    bit chk_stable = 1'b1;

    logic [35:0] wr_q[$];
    int          done_cnt;

    uart_boot_ctrl #(
        .ADDR_W     (TB_ADDR_W),
        .BASE_ADDR  (TB_BASE),
        .TIMEOUT_CYC(TB_TIMEOUT),
        .CNT_W      (26)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rx_valid_i  (rx_valid_i),
        .rx_byte_i   (rx_byte_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .core_rst_n_o(core_rst_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: grant after gnt_delay cycles of request, optional
    // random grants while no request is pending.
    initial begin
        int stall = 0;
        mem_gnt_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            mem_gnt_i = 1'b0;
            if (mem_req_o && !gnt_block) begin
                if (stall >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    stall     = 0;
                end else begin
                    stall++;
                end
            end else begin
                stall = 0;
                if (!mem_req_o && gnt_noise) mem_gnt_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Write collector and request-stability monitor.
    initial begin
        bit                   prev_pend = 1'b0;
        logic [TB_ADDR_W-1:0] prev_addr;
        logic [31:0]          prev_data;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                prev_pend = 1'b0;
            end else begin
                if (chk_stable && prev_pend)
                    check("req_held", {mem_req_o, mem_addr_o, mem_wdata_o}, {1'b1, prev_addr, prev_data});
                if (mem_req_o && mem_gnt_i) wr_q.push_back({mem_addr_o, mem_wdata_o});
                if (done_o) done_cnt++;
                prev_pend = mem_req_o && !mem_gnt_i;
                prev_addr = mem_addr_o;
                prev_data = mem_wdata_o;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy_o; i++) begin
            @(posedge clk_i); #1;
        end
        check("idle_wait", busy_o, 1'b0);
    endtask

    // One complete load; the expected outcome comes from the payload alone.
    task automatic do_load(input logic [7:0] pl[$], input logic [7:0] csum_byte,
                           input int gap_min, input int gap_max);
        int         n_words = pl.size() / 4;
        logic [7:0] sum     = 8'd0;
        bit         ok;
        logic [31:0] w;
        logic [TB_ADDR_W-1:0] a;
        foreach (pl[i]) sum += pl[i];
        ok = (csum_byte == sum);
        wr_q.delete();
        done_cnt = 0;
        send_byte(8'h5F, 0);
        send_byte(8'h70, 0);
        check("busy_after_p", busy_o, 1'b1);
        check("held_after_p", core_rst_n_o, 1'b0);
        send_byte(8'(n_words), $urandom_range(gap_min, gap_max));
        send_byte(8'(n_words >> 8), $urandom_range(gap_min, gap_max));
        foreach (pl[i]) send_byte(pl[i], $urandom_range(gap_min, gap_max));
        send_byte(csum_byte, 0);
        wait_idle(5000);
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        check("n_writes", wr_q.size(), n_words);
        for (int i = 0; i < n_words && i < wr_q.size(); i++) begin
            w = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
            a = TB_ADDR_W'(TB_BASE + i);
            check("write", wr_q[i], {a, w});
        end
        check("done_pulses", done_cnt, ok ? 1 : 0);
        check("err", err_o, !ok);
        check("core_rst_n", core_rst_n_o, ok);
    endtask

    function automatic logic [7:0] sum8(input logic [7:0] pl[$]);
        logic [7:0] s = 8'd0;
        foreach (pl[i]) s += pl[i];
        return s;
    endfunction

    initial begin
        logic [7:0] pl[$];
        logic [7:0] cs;
        int         nw;

        reset_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'h00;
        repeat (3) @(negedge clk_i);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_addr", mem_addr_o, TB_ADDR_W'(TB_BASE));
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("rst_core", core_rst_n_o, 1'b1);
        check("rst_flags", {busy_o, done_o, err_o}, 3'b000);
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        // Basic single-word load.
        pl = '{8'h78, 8'h56, 8'h34, 8'h12};
        do_load(pl, 8'h14, 0, 2);
        if (wr_q.size() > 0) check("word0_const", wr_q[0], {4'd0, 32'h12345678});

        // Two words with slow grants.
        gnt_delay = 20;
        pl.delete();
        repeat (8) pl.push_back(8'($urandom));
        do_load(pl, sum8(pl), 8, 10);

        // Bad checksum, then a good load recovers.
        gnt_delay = 1;
        do_load(pl, sum8(pl) + 8'd1, 1, 3);
        do_load(pl, sum8(pl), 1, 3);

        // "_x" starts nothing; "__p" then starts an empty load.
        send_byte(8'h5F, 0);
        send_byte(8'h78, 0);
        check("idle_after_x", busy_o, 1'b0);
        send_byte(8'h5F, 0);
        pl.delete();
        do_load(pl, 8'h00, 0, 1);

        // Randomized loads, some wrapping the address, some corrupted.
        gnt_noise = 1'b1;
        for (int t = 0; t < 8; t++) begin
            gnt_delay = $urandom_range(0, 10);
            nw = $urandom_range(0, 20);
            pl.delete();
            repeat (4 * nw) pl.push_back(8'($urandom));
            cs = sum8(pl);
            if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
            do_load(pl, cs, 3, 6);
        end
        gnt_noise = 1'b0;

        // Overrun: second word completes while the first is still pending.
        chk_stable = 1'b0;
        gnt_block  = 1'b1;
        wr_q.delete();
        send_byte(8'h5F, 0);
        send_byte(8'h70, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        check("ovr_err", err_o, 1'b1);
        check("ovr_idle", busy_o, 1'b0);
        check("ovr_req", mem_req_o, 1'b0);
        check("ovr_held", core_rst_n_o, 1'b0);
        check("ovr_writes", wr_q.size(), 0);

        // Async reset with a request outstanding.
        send_byte(8'h5F, 0);
        send_byte(8'h70, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        check("pre_rst_req", mem_req_o, 1'b1);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("arst_req", mem_req_o, 1'b0);
        check("arst_state", {busy_o, err_o, core_rst_n_o}, 3'b001);
        check("arst_addr", {mem_addr_o, mem_wdata_o}, {TB_ADDR_W'(TB_BASE), 32'h0});
        @(negedge clk_i);
        reset_i   = 1'b1;
        gnt_block = 1'b0;
        @(posedge clk_i); #1;
        chk_stable = 1'b1;

        // Stall after two payload bytes.
        send_byte(8'h5F, 0);
        send_byte(8'h70, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
`ifdef UART_BOOT_TIMEOUT_EN
        repeat (TB_TIMEOUT - 1) @(posedge clk_i);
        #1;
        check("to_early", {err_o, busy_o}, 2'b01);
        @(posedge clk_i); #1;
        check("to_err", err_o, 1'b1);
        check("to_idle", busy_o, 1'b0);
        check("to_req", mem_req_o, 1'b0);
`else
        repeat (TB_TIMEOUT + 50) @(posedge clk_i);
        #1;
        check("no_to_busy", busy_o, 1'b1);
        check("no_to_err", err_o, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
